// File: rtl/duck_shot_resolver.sv
// Debounced trigger -> one-frame scan of the duck sprite at the crosshair -> hit/miss pulse,
// BCD score and remaining-shots bookkeeping.
module duck_shot_resolver #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COOLDOWN_CYCLES = 2500000,
  parameter int unsigned MAX_SHOTS       = 3,
  parameter logic [9:0]  H_LAST          = 10'd799,
  parameter logic [9:0]  V_LAST          = 10'd524,
  parameter logic [5:0]  TRANSPARENT     = 6'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       reload,
  input  logic [9:0] cross_x,
  input  logic [9:0] cross_y,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       duck_draw,
  input  logic [5:0] duck_data,
  output logic       collision,
  output logic       miss,
  output logic [7:0] score,
  output logic [1:0] shots_left,
  output logic       busy
);

  // state      | meaning
  // S_IDLE     | waiting for a fire edge with shots remaining
  // S_WAIT     | shot armed, waiting for the next frame origin
  // S_SCAN     | sampling the sprite at the crosshair for one whole frame
  // S_RESOLVE  | one cycle: register collision or miss, bump score
  // S_COOLDOWN | dead time before the next shot can arm
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_RESOLVE, S_COOLDOWN} state_t;

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]      SHOTS_FULL = 2'(MAX_SHOTS);

  state_t            state, state_next;
  logic              trig_s1, trig_s2;
  logic              db_level, db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic [CD_W-1:0]   cd_cnt;
  logic              hit_flag;
  logic              fire, fire_take, frame_start, frame_end, pixel_hit;
  logic [7:0]        score_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
    end
  end

  // db_cnt counts consecutive synced samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      db_prev <= db_level;
      if (trig_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= trig_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign fire        = db_level & ~db_prev;
  assign fire_take   = (state == S_IDLE) && fire && (shots_left != 2'd0);
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign frame_end   = (hcount == H_LAST) && (vcount == V_LAST);
  assign pixel_hit   = duck_draw && (duck_data != TRANSPARENT) &&
                       (hcount == cross_x) && (vcount == cross_y);
  assign busy        = (state != S_IDLE);

  always_comb begin
    score_inc = score;
    if (score != 8'h99) begin
      if (score[3:0] == 4'd9) score_inc = {score[7:4] + 4'd1, 4'd0};
      else                    score_inc = {score[7:4], score[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (fire_take) state_next = S_WAIT;
      S_WAIT:     if (frame_start) state_next = S_SCAN;
      S_SCAN:     if (frame_end) state_next = S_RESOLVE;
      S_RESOLVE:  state_next = S_COOLDOWN;
      S_COOLDOWN: if (cd_cnt == CD_LAST) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_flag   <= 1'b0;
      collision  <= 1'b0;
      miss       <= 1'b0;
      score      <= 8'h00;
      shots_left <= SHOTS_FULL;
      cd_cnt     <= '0;
    end else begin
      collision <= (state == S_RESOLVE) && hit_flag;
      miss      <= (state == S_RESOLVE) && !hit_flag;

      if (state == S_WAIT)                 hit_flag <= 1'b0;
      else if (state == S_SCAN && pixel_hit) hit_flag <= 1'b1;

      if (state == S_RESOLVE && hit_flag) score <= score_inc;

      if (state == S_COOLDOWN) cd_cnt <= (cd_cnt == CD_LAST) ? '0 : cd_cnt + 1'b1;
      else                     cd_cnt <= '0;

      // A reload coinciding with an accepted fire still spends that shot.
      if (fire_take)   shots_left <= reload ? SHOTS_FULL - 2'd1 : shots_left - 2'd1;
      else if (reload) shots_left <= SHOTS_FULL;
    end
  end

endmodule
